// File: rtl/softcast_fft_pkg.sv
// Shared definitions for the radix-4 FFT twiddle path: FSM states, frame size, default stage offsets.
package softcast_fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int FFT_LOG2N = 12;
    localparam int FFT_N     = 1 << FFT_LOG2N;

    localparam int OFF2_DEF = 3;
    localparam int OFF3_DEF = 6;
    localparam int OFF4_DEF = 9;
    localparam int OFF5_DEF = 12;
    localparam int OFF6_DEF = 15;

    // Stage k indexes a 4^k-entry twiddle table.
    function automatic int stage_aw(input int k);
        return 2 * k;
    endfunction

endpackage

// File: rtl/omega_stage_addr.sv
// One butterfly stage's twiddle address and active flag, derived from the frame tick counter.
// Purely combinational; zero latency, no backpressure.
module omega_stage_addr
    import softcast_fft_pkg::*;
#(
    parameter int K     = 2,
    parameter int OFF   = 3,
    parameter int TW    = FFT_LOG2N + 5,
    parameter int NSAMP = FFT_N,
    localparam int AW   = stage_aw(K)
) (
    input  logic [TW-1:0] i_t,
    input  logic          i_busy,
    output logic [AW-1:0] o_addr,
    output logic          o_act
);

    localparam logic [TW-1:0] LO     = TW'(OFF);
    localparam logic [TW-1:0] HI     = TW'(OFF + NSAMP);
    localparam logic [AW-1:0] OFF_AW = AW'(OFF);

    logic          w_act;
    logic [AW-1:0] w_diff;

    assign w_act  = i_busy && (i_t >= LO) && (i_t < HI);
    // Only the low 2k bits matter: the address wraps modulo 4^k.
    assign w_diff = i_t[AW-1:0] - OFF_AW;

    assign o_act  = w_act;
    assign o_addr = w_act ? w_diff : '0;

endmodule

// File: rtl/omega_frame_sequencer.sv
// Frame controller for the omega ROM path: counts N samples, drains stage latency, drives per-stage twiddle addresses.
// Addresses follow the registered tick counter combinationally; in_valid low stalls RUN; abort returns to IDLE next cycle.
// OMEGA_SEQ_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module omega_frame_sequencer
    import softcast_fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N,
    parameter int OFF2  = OFF2_DEF,
    parameter int OFF3  = OFF3_DEF,
    parameter int OFF4  = OFF4_DEF,
    parameter int OFF5  = OFF5_DEF,
    parameter int OFF6  = OFF6_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    output logic        omega_en,
    output logic [3:0]  addr2,
    output logic [5:0]  addr3,
    output logic [7:0]  addr4,
    output logic [9:0]  addr5,
    output logic [11:0] addr6,
    output logic [4:0]  stage_act,
    output logic        busy,
    output logic        done
`ifdef OMEGA_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int TW    = LOG2N + 5;
    localparam int SW    = LOG2N + 1;
    localparam int NSAMP = 1 << LOG2N;

    localparam logic [SW-1:0] S_LAST = SW'(NSAMP - 1);
    localparam logic [TW-1:0] T_LAST = TW'(NSAMP + OFF6 - 1);

    generate
        if (!((OFF2 <= OFF3) && (OFF3 <= OFF4) && (OFF4 <= OFF5) && (OFF5 <= OFF6))) begin : g_bad_offsets
            $error("omega_frame_sequencer: stage offsets must be non-decreasing");
        end
    endgenerate

    seq_state_t    r_state;
    logic [TW-1:0] r_t;
    logic [SW-1:0] r_s;
    logic          r_busy;
    logic          r_done;
    logic          w_tick;
    logic [4:0]    w_act;

    assign w_tick = ((r_state == ST_RUN) && in_valid) || (r_state == ST_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
            r_s     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state <= ST_IDLE;
                r_t     <= '0;
                r_s     <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_state <= ST_RUN;
                            r_t     <= '0;
                            r_s     <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_tick) begin
                            r_t <= r_t + TW'(1);
                            r_s <= r_s + SW'(1);
                            if (r_s == S_LAST) begin
                                r_state <= ST_FLUSH;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        r_t <= r_t + TW'(1);
                        // Last tick: stage 6 has just consumed sample N-1.
                        if (r_t == T_LAST) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign omega_en  = w_tick;
    assign busy      = r_busy;
    assign done      = r_done;
    assign stage_act = w_act;

    omega_stage_addr #(.K(2), .OFF(OFF2), .TW(TW), .NSAMP(NSAMP)) u_stage2 (
        .i_t(r_t), .i_busy(r_busy), .o_addr(addr2), .o_act(w_act[0])
    );
    omega_stage_addr #(.K(3), .OFF(OFF3), .TW(TW), .NSAMP(NSAMP)) u_stage3 (
        .i_t(r_t), .i_busy(r_busy), .o_addr(addr3), .o_act(w_act[1])
    );
    omega_stage_addr #(.K(4), .OFF(OFF4), .TW(TW), .NSAMP(NSAMP)) u_stage4 (
        .i_t(r_t), .i_busy(r_busy), .o_addr(addr4), .o_act(w_act[2])
    );
    omega_stage_addr #(.K(5), .OFF(OFF5), .TW(TW), .NSAMP(NSAMP)) u_stage5 (
        .i_t(r_t), .i_busy(r_busy), .o_addr(addr5), .o_act(w_act[3])
    );
    omega_stage_addr #(.K(6), .OFF(OFF6), .TW(TW), .NSAMP(NSAMP)) u_stage6 (
        .i_t(r_t), .i_busy(r_busy), .o_addr(addr6), .o_act(w_act[4])
    );

`ifdef OMEGA_SEQ_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (r_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_omega_frame_sequencer.sv
// Directed bench for omega_frame_sequencer: reset, full frame, stalls, abort, ignored starts.
module tb_omega_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, in_valid;
    logic        omega_en, busy, done;
    logic [3:0]  addr2;
    logic [5:0]  addr3;
    logic [7:0]  addr4;
    logic [9:0]  addr5;
    logic [11:0] addr6;
    logic [4:0]  stage_act;
`ifdef OMEGA_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    omega_frame_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
        .omega_en(omega_en), .addr2(addr2), .addr3(addr3), .addr4(addr4),
        .addr5(addr5), .addr6(addr6), .stage_act(stage_act), .busy(busy), .done(done)
`ifdef OMEGA_SEQ_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        total++; if (omega_en !== 1'b0) begin bad++; $display("FAIL rst_omega_en: got %b want 0", omega_en); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
        total++; if (stage_act !== 5'b0) begin bad++; $display("FAIL rst_stage_act: got %b want 00000", stage_act); end
        total++; if ({addr2, addr3, addr4, addr5, addr6} !== 40'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", {addr2, addr3, addr4, addr5, addr6}); end
        @(negedge clk);
        rst = 1'b0;
        step();
        in_valid = 1'b1;
        #1;
        total++; if (omega_en !== 1'b0) begin bad++; $display("FAIL idle_in_valid: got %b want 0", omega_en); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midrun();
        start = 1'b1; in_valid = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        total++; if (stage_act !== 5'b11111 || addr2 !== 4'd1 || addr6 !== 12'd85) begin
            bad++; $display("FAIL mid_t100: got act=%b a2=%0d a6=%0d want 11111 1 85", stage_act, addr2, addr6); end
        #2 rst = 1'b1;
        #1;
        total++; if (omega_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mid_rst_ctrl: got en=%b busy=%b done=%b want 000", omega_en, busy, done); end
        total++; if (stage_act !== 5'b0 || {addr2, addr3, addr4, addr5, addr6} !== 40'h0) begin
            bad++; $display("FAIL mid_rst_addr: got act=%b addr=%h want 0 0", stage_act, {addr2, addr3, addr4, addr5, addr6}); end
        @(negedge clk);
        rst = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        total++; if (busy !== 1'b1 || omega_en !== 1'b1 || stage_act !== 5'b0 || addr2 !== 4'd0) begin
            bad++; $display("FAIL restart_t0: got busy=%b en=%b act=%b a2=%0d want 1 1 00000 0", busy, omega_en, stage_act, addr2); end
        repeat (3) step();
        total++; if (stage_act !== 5'b00001 || addr2 !== 4'd0) begin
            bad++; $display("FAIL restart_t3: got act=%b a2=%0d want 00001 0", stage_act, addr2); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL restart_abort: got busy=%b done=%b want 00", busy, done); end
    endtask

    task automatic test_full_frame();
        int en_cnt;
        int done_cnt;
        en_cnt = 0; done_cnt = 0;
        start = 1'b1; in_valid = 1'b1;
        step();
        start = 1'b0;
        #1;
        for (int i = 0; i < 4111; i++) begin
            if (omega_en === 1'b1) en_cnt++;
            if (done !== 1'b0) done_cnt++;
            if (i == 0) begin
                total++; if (busy !== 1'b1 || stage_act !== 5'b0 || addr2 !== 4'd0) begin
                    bad++; $display("FAIL ff_t0: got busy=%b act=%b a2=%0d want 1 00000 0", busy, stage_act, addr2); end
            end
            if (i == 2) begin
                total++; if (stage_act[0] !== 1'b0) begin bad++; $display("FAIL ff_t2_act: got %b want 0", stage_act[0]); end
            end
            if (i == 3) begin
                total++; if (stage_act !== 5'b00001 || addr2 !== 4'd0) begin
                    bad++; $display("FAIL ff_t3: got act=%b a2=%0d want 00001 0", stage_act, addr2); end
            end
            if (i == 18) begin
                total++; if (addr2 !== 4'd15 || stage_act !== 5'b11111) begin
                    bad++; $display("FAIL ff_t18: got a2=%0d act=%b want 15 11111", addr2, stage_act); end
            end
            if (i == 19) begin
                total++; if (addr2 !== 4'd0 || addr3 !== 6'd13) begin
                    bad++; $display("FAIL ff_t19: got a2=%0d a3=%0d want 0 13", addr2, addr3); end
            end
            if (i == 4098) begin
                total++; if (stage_act !== 5'b11111 || addr2 !== 4'd15) begin
                    bad++; $display("FAIL ff_t4098: got act=%b a2=%0d want 11111 15", stage_act, addr2); end
            end
            if (i == 4099) begin
                total++; if (stage_act !== 5'b11110 || addr2 !== 4'd0) begin
                    bad++; $display("FAIL ff_t4099: got act=%b a2=%0d want 11110 0", stage_act, addr2); end
            end
            if (i == 4110) begin
                total++; if (addr6 !== 12'd4095 || stage_act !== 5'b10000 || addr5 !== 10'd0) begin
                    bad++; $display("FAIL ff_t4110: got a6=%0d act=%b a5=%0d want 4095 10000 0", addr6, stage_act, addr5); end
            end
            step();
        end
        total++; if (en_cnt !== 4111) begin bad++; $display("FAIL ff_tick_count: got %0d want 4111", en_cnt); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL ff_early_done: got %0d want 0", done_cnt); end
        total++; if (done !== 1'b1 || omega_en !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL ff_done_cycle: got done=%b en=%b busy=%b want 1 0 0", done, omega_en, busy); end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ff_after_done: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_stall();
        int m;
        m = 0;
        start = 1'b1; in_valid = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8200 && m < 4096; c++) begin
            in_valid = (c % 2 == 0);
            #1;
            total++; if (omega_en !== in_valid) begin bad++; $display("FAIL st_en_c%0d: got %b want %b", c, omega_en, in_valid); end
            if (m == 20) begin
                total++; if (addr2 !== 4'd1 || addr6 !== 12'd5 || stage_act !== 5'b11111) begin
                    bad++; $display("FAIL st_hold_c%0d: got a2=%0d a6=%0d act=%b want 1 5 11111", c, addr2, addr6, stage_act); end
            end
            step();
            if (in_valid) m++;
        end
        total++; if (m !== 4096) begin bad++; $display("FAIL st_run_budget: got %0d want 4096", m); end
        for (int k = 0; k < 15; k++) begin
            in_valid = k[0];
            #1;
            total++; if (omega_en !== 1'b1 || busy !== 1'b1) begin
                bad++; $display("FAIL st_flush_k%0d: got en=%b busy=%b want 1 1", k, omega_en, busy); end
            step();
        end
        total++; if (done !== 1'b1 || omega_en !== 1'b0) begin bad++; $display("FAIL st_done: got done=%b en=%b want 1 0", done, omega_en); end
        step();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL st_idle: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_abort_flush();
        int hi_cnt;
        hi_cnt = 0;
        start = 1'b1; in_valid = 1'b1;
        step();
        start = 1'b0;
        repeat (4101) step();
        total++; if (busy !== 1'b1 || omega_en !== 1'b1 || stage_act !== 5'b11110) begin
            bad++; $display("FAIL ab_in_flush: got busy=%b en=%b act=%b want 1 1 11110", busy, omega_en, stage_act); end
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || omega_en !== 1'b0 || stage_act !== 5'b0) begin
            bad++; $display("FAIL ab_idle: got busy=%b done=%b en=%b act=%b want 0 0 0 00000", busy, done, omega_en, stage_act); end
        repeat (20) begin
            step();
            if (busy !== 1'b0 || done !== 1'b0) hi_cnt++;
        end
        total++; if (hi_cnt !== 0) begin bad++; $display("FAIL ab_no_activity: got %0d want 0", hi_cnt); end
        test_full_frame();
`ifdef OMEGA_SEQ_FRAME_CNT_EN
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL ab_frame_cnt: got %0d want 3", frame_cnt); end
`endif
    endtask

    task automatic test_start_ignored();
        int done_cnt;
        done_cnt = 0;
        start = 1'b1; in_valid = 1'b1;
        step();
        for (int i = 0; i < 4111; i++) begin
            start = (i == 50 || i == 4100);
            #1;
            if (done !== 1'b0) done_cnt++;
            step();
        end
        start = 1'b1;
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL si_done_on_time: got %b want 1", done); end
        done_cnt++;
        step();
        start = 1'b0;
        repeat (5) begin
            if (done !== 1'b0) done_cnt++;
            step();
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL si_start_in_done: got busy=%b want 0", busy); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL si_done_count: got %0d want 1", done_cnt); end
`ifdef OMEGA_SEQ_FRAME_CNT_EN
        total++; if (frame_cnt !== 16'd4) begin bad++; $display("FAIL si_frame_cnt: got %0d want 4", frame_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_full_frame();
        test_stall();
        test_abort_flush();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
